// File: rtl/pixel_stream_tx.sv
// Raster-timed pixel source: buffers host pixels in a small FIFO and emits one
// IMG_W x IMG_H frame per start pulse, with horizontal and vertical blanking gaps.
module pixel_stream_tx #(
    parameter int DATA_W     = 16,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 512,
    parameter int HBLANK     = 4,
    parameter int VBLANK     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_en,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int X_W    = $clog2(IMG_W);
    localparam int Y_W    = $clog2(IMG_H);
    localparam int B_MAX  = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int B_W    = (B_MAX > 0) ? $clog2(B_MAX + 1) : 1;
    localparam int A_W    = $clog2(FIFO_DEPTH);
    localparam int C_W    = A_W + 1;

    localparam logic [X_W-1:0] X_LAST  = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(IMG_H - 1);
    localparam logic [B_W-1:0] HB_LAST = B_W'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [B_W-1:0] VB_LAST = B_W'((VBLANK > 0) ? VBLANK - 1 : 0);
    localparam logic [C_W-1:0] C_FULL  = C_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [X_W-1:0]     r_x, w_next_x;
    logic [Y_W-1:0]     r_y, w_next_y;
    logic [B_W-1:0]     r_blank, w_next_blank;

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [A_W-1:0]     r_wr, r_rd;
    logic [C_W-1:0]     r_count;

    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_en, r_sof, r_eol, r_busy, r_done, r_underrun;

    logic               w_full, w_empty, w_push, w_pop;
    logic               w_stall, w_start, w_done;

    // Host handshake: a word transfers on any clock edge where s_valid && s_ready.
    // s_ready depends only on the registered count, so the host never sees a
    // combinational path from its own s_valid.
    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);
    assign s_ready = !w_full;
    assign w_push  = s_valid && !w_full;

    always_comb begin
        w_next_state = r_state;
        w_next_x     = r_x;
        w_next_y     = r_y;
        w_next_blank = r_blank;
        w_pop        = 1'b0;
        w_stall      = 1'b0;
        w_start      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_ACTIVE;
                    w_next_x     = '0;
                    w_next_y     = '0;
                    w_start      = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_empty) begin
                    w_stall = 1'b1;
                end else begin
                    w_pop = 1'b1;
                    if (r_x == X_LAST) begin
                        w_next_x = '0;
                        if (r_y == Y_LAST) begin
                            w_next_y = '0;
                            if (VBLANK > 0) begin
                                w_next_state = S_VBLANK;
                                w_next_blank = '0;
                            end else begin
                                w_next_state = S_IDLE;
                                w_done       = 1'b1;
                            end
                        end else begin
                            w_next_y = r_y + Y_W'(1);
                            if (HBLANK > 0) begin
                                w_next_state = S_HBLANK;
                                w_next_blank = '0;
                            end
                        end
                    end else begin
                        w_next_x = r_x + X_W'(1);
                    end
                end
            end
            S_HBLANK: begin
                if (r_blank == HB_LAST) w_next_state = S_ACTIVE;
                else                    w_next_blank = r_blank + B_W'(1);
            end
            S_VBLANK: begin
                if (r_blank == VB_LAST) begin
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                end else begin
                    w_next_blank = r_blank + B_W'(1);
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_blank <= '0;
        end else begin
            r_state <= w_next_state;
            r_x     <= w_next_x;
            r_y     <= w_next_y;
            r_blank <= w_next_blank;
        end
    end

    // Storage is not reset; reset only clears the pointers, which discards contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + A_W'(1);
            if (w_pop)  r_rd <= r_rd + A_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_W'(1);
                2'b01:   r_count <= r_count - C_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_en   <= 1'b0;
            r_sof      <= 1'b0;
            r_eol      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_pop) r_out_data <= r_mem[r_rd];
            r_out_en <= w_pop;
            r_sof    <= w_pop && (r_x == '0) && (r_y == '0);
            r_eol    <= w_pop && (r_x == X_LAST);
            r_busy   <= (w_next_state != S_IDLE);
            r_done   <= w_done;
            if (w_start)      r_underrun <= 1'b0;
            else if (w_stall) r_underrun <= 1'b1;
        end
    end

    assign out_data   = r_out_data;
    assign out_en     = r_out_en;
    assign sof        = r_sof;
    assign eol        = r_eol;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Self-checking bench for pixel_stream_tx: a frame-level reference model
// (pixel index, gap counter, FIFO queue) compared against the DUT every cycle.
module tb_pixel_stream_tx;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int HB = 2;
    localparam int VB = 3;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] out_data;
    logic          out_en, sof, eol, busy, frame_done, underrun;

    int total = 0;
    int bad   = 0;

    pixel_stream_tx #(
        .DATA_W(DW), .IMG_W(W), .IMG_H(H), .HBLANK(HB), .VBLANK(VB), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .out_data(out_data), .out_en(out_en), .sof(sof), .eol(eol),
        .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The frame is a count of emitted pixels; blanking is a countdown of idle
    // cycles; the FIFO is a queue. Updated at each clock edge from the inputs.
    logic [DW-1:0] m_q[$];
    bit            m_busy  = 0;
    bit            m_final = 0;
    int            m_pix   = 0;
    int            m_gap   = 0;
    logic [DW-1:0] e_data  = '0;
    bit            e_en = 0, e_sof = 0, e_eol = 0, e_busy = 0, e_fd = 0, e_und = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_busy = 0; m_final = 0; m_pix = 0; m_gap = 0;
            e_data = '0; e_en = 0; e_sof = 0; e_eol = 0; e_busy = 0; e_fd = 0; e_und = 0;
        end else begin
            bit push;
            push = s_valid && (m_q.size() < FD);
            e_en = 0; e_sof = 0; e_eol = 0; e_fd = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_pix = 0; m_gap = 0; m_final = 0; e_und = 0;
                end
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0 && m_final) begin
                    m_busy = 0; e_fd = 1;
                end
            end else if (m_q.size() > 0) begin
                e_data = m_q.pop_front();
                e_en   = 1;
                e_sof  = (m_pix == 0);
                e_eol  = (m_pix % W == W - 1);
                m_pix++;
                if (m_pix == W * H) begin
                    if (VB == 0) begin
                        m_busy = 0; e_fd = 1;
                    end else begin
                        m_gap = VB; m_final = 1;
                    end
                end else if (m_pix % W == 0) begin
                    m_gap = HB;
                end
            end else begin
                e_und = 1;
            end
            if (push) m_q.push_back(s_data);
            e_busy = m_busy;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("s_ready",    {31'd0, s_ready},    {31'd0, m_q.size() < FD});
        chk("out_en",     {31'd0, out_en},     {31'd0, e_en});
        chk("out_data",   {16'd0, out_data},   {16'd0, e_data});
        chk("sof",        {31'd0, sof},        {31'd0, e_sof});
        chk("eol",        {31'd0, eol},        {31'd0, e_eol});
        chk("busy",       {31'd0, busy},       {31'd0, e_busy});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
        chk("underrun",   {31'd0, underrun},   {31'd0, e_und});
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic push_word(input logic [DW-1:0] d);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL push_timeout: s_ready stayed 0 for word %0h", d);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frame_done(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < limit);
        chk("frame_done_wait", {31'd0, frame_done}, 32'd1);
    endtask

    logic [12:0] pat;
    logic [7:0]  sof_mask, eol_mask;
    logic [DW-1:0] got[$];
    int fd_cnt, acc, cnt;

    initial begin
        // reset
        repeat (3) @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // full frame with preload
        for (int i = 1; i <= 4; i++) push_word(DW'(i));
        chk("preload_full", {31'd0, s_ready}, 32'd0);
        pulse_start();
        pat = '0; sof_mask = '0; eol_mask = '0; got.delete(); fd_cnt = 0;
        fork
            for (int i = 5; i <= 8; i++) push_word(DW'(i));
            for (int k = 0; k < 13; k++) begin
                @(negedge clk);
                pat = {pat[11:0], out_en};
                if (frame_done) fd_cnt += (k == 12) ? 1 : 100;
                if (out_en) begin
                    if (sof) sof_mask[got.size()] = 1'b1;
                    if (eol) eol_mask[got.size()] = 1'b1;
                    got.push_back(out_data);
                end
            end
        join
        chk("t2_pattern", {19'd0, pat}, {19'd0, 13'b1111001111000});
        chk("t2_done_at_end", fd_cnt, 1);
        chk("t2_npix", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++) chk("t2_data", {16'd0, got[k]}, k + 1);
        chk("t2_sof", {24'd0, sof_mask}, 32'h01);
        chk("t2_eol", {24'd0, eol_mask}, 32'h88);
        chk("t2_underrun", {31'd0, underrun}, 32'd0);

        // underrun: empty FIFO, one word every 3 cycles
        pulse_start();
        fork
            for (int i = 0; i < 8; i++) begin
                push_word(DW'(16'h0100 + i));
                repeat (2) @(negedge clk);
            end
            begin
                @(negedge clk);
                chk("t3_underrun_set", {31'd0, underrun}, 32'd1);
                wait_frame_done(200);
            end
        join

        // back-to-back with ignored start pulses during busy
        for (int i = 0; i < 4; i++) push_word(DW'(16'h0200 + i));
        pulse_start();
        chk("t3_underrun_clear", {31'd0, underrun}, 32'd0);
        fork
            for (int i = 4; i < 12; i++) push_word(DW'(16'h0200 + i));
            begin
                for (int p = 0; p < 3; p++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    pulse_start();
                end
                wait_frame_done(200);
            end
        join
        chk("t4_fifo_full", {31'd0, s_ready}, 32'd0);
        chk("t4_busy_gap", {31'd0, busy}, 32'd0);
        pulse_start();
        chk("t4_busy_again", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t4_sof_next", {31'd0, sof & out_en}, 32'd1);
        chk("t4_sof_data", {16'd0, out_data}, 32'h0208);
        fork
            for (int i = 12; i < 16; i++) push_word(DW'(16'h0200 + i));
            wait_frame_done(200);
        join

        // reset mid-line
        for (int i = 0; i < 4; i++) push_word(DW'(16'h0300 + i));
        pulse_start();
        cnt = 0;
        for (int n = 0; n < 50 && cnt < 2; n++) begin
            @(negedge clk);
            if (out_en) cnt++;
        end
        chk("t5_two_pix", cnt, 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_async_out_en", {31'd0, out_en}, 32'd0);
        chk("t1_async_out_data", {16'd0, out_data}, 32'd0);
        chk("t1_async_flags", {26'd0, sof, eol, busy, frame_done, underrun, s_ready}, 32'h01);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_word(DW'(16'hA000 + i));
        pulse_start();
        fork
            for (int i = 4; i < 8; i++) push_word(DW'(16'hA000 + i));
            begin
                cnt = 0;
                while (!out_en && cnt < 50) begin
                    @(negedge clk);
                    cnt++;
                end
                chk("t5_first_data", {16'd0, out_data}, 32'hA000);
                chk("t5_first_sof", {31'd0, sof}, 32'd1);
                wait_frame_done(200);
            end
        join

        // FIFO boundary: six words offered while idle
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            s_data  = DW'(16'hB000 + i);
            s_valid = 1'b1;
            if (s_ready) acc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("t6_accepted", acc, 4);
        chk("t6_s_ready", {31'd0, s_ready}, 32'd0);
        pulse_start();
        got.delete();
        fork
            for (int i = 6; i < 10; i++) push_word(DW'(16'hB000 + i));
            begin
                cnt = 0;
                do begin
                    @(negedge clk);
                    cnt++;
                    if (out_en) got.push_back(out_data);
                end while (!frame_done && cnt < 200);
            end
        join
        chk("t6_npix", got.size(), 8);
        for (int k = 0; k < 4 && k < got.size(); k++) chk("t6_data", {16'd0, got[k]}, 32'hB000 + k);

        // randomized traffic with random start pulses
        for (int n = 0; n < 600; n++) begin
            if (!(s_valid && !s_ready)) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = DW'($urandom);
            end
            start = ($urandom_range(0, 9) == 0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        start   = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_stream_tx.md
Name: pixel_stream_tx

Overview:
Raster-timed pixel source that drives the edge-detection pipeline's streaming input (in_data/enable).
- Accepts pixels from a host-side valid/ready interface into a small FIFO.
- On a start pulse, emits exactly one IMG_W x IMG_H frame in raster order, with programmable horizontal and vertical blanking gaps.
- Flags start-of-frame and end-of-line, and reports frame completion and underrun.

Parameters:
DATA_W, 16, pixel width
IMG_W, 640, pixels per line (>=2)
IMG_H, 512, lines per frame (>=2)
HBLANK, 4, idle cycles after each line except the last (0 allowed)
VBLANK, 16, idle cycles after the last line before frame_done (0 allowed)
FIFO_DEPTH, 16, ingress FIFO entries, power of 2, >=2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  frame start pulse; honoured only in IDLE
s_data  in  DATA_W  host pixel
s_valid  in  1  host pixel valid
s_ready  out  1  FIFO not full
out_data  out  DATA_W  pixel to pipeline in_data
out_en  out  1  pixel valid, drives pipeline enable
sof  out  1  high with first pixel of frame (x=0,y=0)
eol  out  1  high with each pixel x=IMG_W-1
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at end of frame
underrun  out  1  sticky: ACTIVE stall seen this frame

Behaviour:
Clock and reset:
- Single clock clk; reset rst_n asynchronous, active-low.
- Reset values: out_data=0, out_en=0, sof=0, eol=0, busy=0, frame_done=0, underrun=0. FIFO empty, so s_ready=1. State IDLE, x=y=0.
- Reset mid-frame aborts the frame and discards FIFO contents. There is no partial-frame resume.

FIFO:
- Push when s_valid&&s_ready. s_ready = !full (combinational from registered count).
- Pushes are accepted in every state, so the host may preload before start.
- No write-to-read bypass: a pop only consumes entries present at the start of the cycle.
- Push and pop in the same cycle leave the count unchanged.
- When full, s_ready=0; held s_valid never overwrites data.

Outputs:
- All outputs except s_ready are registered.
- Pop in cycle t produces out_en=1 and out_data=popped word in cycle t+1.
- out_en=0 cycles hold the previous out_data.
- Minimum latency from handshake to out_en: 2 cycles (handshake cycle, pop cycle, output cycle).

FSM:
- IDLE: start=1 → x=y=0, clear underrun, go to ACTIVE.
- ACTIVE: each cycle with FIFO non-empty, pop and emit pixel (x,y), then advance x.
  - FIFO empty: no emit (stall), set underrun. Pixel order is preserved; stalls never skip coordinates.
  - Emitted pixel x=IMG_W-1 with y<IMG_H-1: x=0, y++. Go to HBLANK if HBLANK>0, else stay in ACTIVE.
  - Emitted pixel x=IMG_W-1 with y=IMG_H-1: go to VBLANK if VBLANK>0, else directly to IDLE with frame_done.
- HBLANK: no pops; count HBLANK cycles, then ACTIVE.
- VBLANK: no pops; count VBLANK cycles, then IDLE.
- frame_done=1 during the first IDLE cycle; busy=0 in that same cycle.
- start is ignored while busy. start in the frame_done cycle is accepted (back-to-back frames).
- sof and eol are qualified by out_en and aligned with their pixel. With IMG_W pixels, eol occurs exactly IMG_H times per frame.

Widths:
- x counter: clog2(IMG_W) bits. y counter: clog2(IMG_H) bits.
- Blank counter: clog2(max(HBLANK,VBLANK)+1) bits.
- FIFO count: clog2(FIFO_DEPTH)+1 bits.

Test Plan:
(All tests use IMG_W=4, IMG_H=2, HBLANK=2, VBLANK=3, FIFO_DEPTH=4.)
1. Reset: assert rst_n=0 asynchronously mid-cycle → all outputs listed above 0 immediately, s_ready=1.
2. Full frame: preload 0x0001..0x0004 (s_ready drops after 4th), pulse start, keep feeding 0x0005..0x0008 → out_en pattern 1111 00 1111 000, then frame_done pulse. Data 0x0001..0x0008 in order; sof with 0x0001; eol with 0x0004 and 0x0008; underrun=0.
3. Underrun: start with empty FIFO, push one word every 3 cycles → out_en one cycle in three, data order intact, underrun=1 by first stall. Next start clears underrun.
4. Back-to-back: assert start in the frame_done cycle with FIFO full → busy stays 0 for exactly that one cycle; next frame's sof follows immediately. start pulses during busy are ignored (no restart, x/y unaffected).
5. Reset mid-line: reset after 2 pixels of line 0 → FIFO empty, outputs 0. Preload and start → sof with the first new word; no stale data emitted.
6. FIFO boundary: in IDLE hold s_valid=1 with 6 distinct words → exactly 4 accepted, s_ready=0. After start, ACTIVE pops with simultaneous pushes keep count constant; emitted sequence equals accepted sequence.
